reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- RV32 integer register file for the single-cycle core: 32 registers, each 32 bits wide.
- Two combinational read ports (rs1, rs2) feed the decode/execute datapath.
- One synchronous write port (rd) takes writeback data.
- Register x0 is hardwired to zero, per the RISC-V ISA.

Parameters:
- DATA_WIDTH, 32, bit width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; the file holds 2**ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears every register.
- rs1_addr  input  ADDR_WIDTH  read port 1 register index.
- rs2_addr  input  ADDR_WIDTH  read port 2 register index.
- rd_addr  input  ADDR_WIDTH  write port register index.
- rd_wren  input  1  write enable for the rd port, active high.
- rd_data  input  DATA_WIDTH  write data.
- rs1_data  output  DATA_WIDTH  contents of register rs1_addr.
- rs2_data  output  DATA_WIDTH  contents of register rs2_addr.

Behaviour:
- Storage:
  - Internal array named register_array, indexed 0..2**ADDR_WIDTH-1.
  - Verification probes register_array hierarchically, so the name and indexing are fixed.
- Reset:
  - rst_n low clears all entries to 0 immediately, without waiting for a clock edge.
  - rs1_data and rs2_data therefore read 0 while reset is asserted.
  - Reset has priority over a write in the same cycle.
- Write:
  - On the rising edge of clk, with rst_n high, rd_wren = 1 and rd_addr != 0: register_array[rd_addr] <= rd_data.
  - Write latency is one edge: the new value is visible in register_array right after that edge.
- x0:
  - Writes to address 0 are discarded.
  - register_array[0] stays 0 at all times.
  - Reads of address 0 return 0.
- Read:
  - Purely combinational, zero latency: rs1_data = register_array[rs1_addr] and rs2_data = register_array[rs2_addr].
  - Outputs update within the same cycle when an address changes.
- Both read ports are independent. They may use the same index, and either may match rd_addr.
- Read-during-write to the same index: without the optional feature, the read returns the pre-edge value until the clock edge, then the new value.
- rd_wren = 0: the array is unchanged regardless of rd_addr and rd_data.
- No X propagation: every address in range is valid, and there is no out-of-range case.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-to-read forwarding.
  - If rd_wren = 1, rd_addr != 0 and rsN_addr == rd_addr, then rsN_data = rd_data combinationally in the same cycle, before the edge commits it.
  - Applies to each read port independently.
  - No bypass while rst_n is low; outputs read 0.
- Undefined:
  - No forwarding; reads always reflect register_array contents.
  - Matches the read-during-write rule in Behaviour.

Test Plan:
- Reset check: assert rst_n = 0 after prior writes -> every register_array entry reads 0, and rs1_data = rs2_data = 0 for addresses 0..31, with no clock edge required.
- Basic write/read:
  - Write 0xDEADBEEF to x5 with rd_wren = 1 and wait one edge -> register_array[5] = 0xDEADBEEF.
  - Then rs1_addr = 5 -> rs1_data = 0xDEADBEEF in the same cycle.
- x0 protection: write 0xFFFFFFFF to x0 -> register_array[0] = 0, and rs1_addr = rs2_addr = 0 returns 0.
- Write disable: rd_wren = 0, rd_addr = 7, rd_data = 0x12345678 over several edges -> x7 keeps its previous value.
- Random sweep:
  - 100 random writes, each to a random address in 0..31 with random data.
  - Each write is checked one edge later against a reference model.
  - Then 100 random (rs1_addr, rs2_addr) pairs -> both outputs equal the model, with x0 reading 0.
- Same-cycle collision: rd_addr = rs1_addr = rs2_addr = 3, rd_data = 0xA5A5A5A5, old x3 = 0x1 -> before the edge, outputs are 0x1 without REGFILE_BYPASS_EN and 0xA5A5A5A5 with it; after the edge, 0xA5A5A5A5 in both builds.

Source files
------------

// File: rtl/reg_file.sv
// RV32 integer register file: 32 x 32-bit, two combinational read ports, one write port.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_wren,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] register_array [0:NumRegs-1];
  logic                  wr_en;

  // x0 is never written, so its reset value of zero holds forever.
  always_comb begin
    wr_en = rd_wren && (rd_addr != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        register_array[i] <= '0;
      end
    end else if (wr_en) begin
      register_array[rd_addr] <= rd_data;
    end
  end

  always_comb begin
    rs1_data = register_array[rs1_addr];
    rs2_data = register_array[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed in reset so outputs track the cleared array.
    if (rst_n && wr_en && (rs1_addr == rd_addr)) begin
      rs1_data = rd_data;
    end
    if (rst_n && wr_en && (rs2_addr == rd_addr)) begin
      rs2_data = rd_data;
    end
`else
    if (!rst_n) begin
      rs1_data = '0;
      rs2_data = '0;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: reset, write/read, x0, write disable, sweep, collision, reset.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_wren;
  logic [31:0] rd_data;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic [31:0] model [0:31];
  int          n_checks;
  int          n_pass;

  reg_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr),
    .rd_addr (rd_addr),
    .rd_wren (rd_wren),
    .rd_data (rd_data),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Drive on the falling edge, commit on the rising edge, return 1 time unit later.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic en);
    @(negedge clk);
    rd_addr = a;
    rd_data = d;
    rd_wren = en;
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    if (en && a != 5'd0) model[a] = d;
  endtask

  initial begin
    logic [4:0]  a;
    logic [4:0]  b;
    logic [31:0] d;
    logic [31:0] coll_exp;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    rd_addr  = '0;
    rd_wren  = 1'b0;
    rd_data  = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    #12;
    check("reset_x0", dut.register_array[0], 32'h0);
    check("reset_x31", dut.register_array[31], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write and same-cycle combinational read
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    check("wr_x5", dut.register_array[5], 32'hDEADBEEF);
    rs1_addr = 5'd5;
    #1;
    check("rd_x5", rs1_data, 32'hDEADBEEF);

    // x0 protection
    do_write(5'd0, 32'hFFFFFFFF, 1'b1);
    check("x0_array", dut.register_array[0], 32'h0);
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #1;
    check("x0_rs1", rs1_data, 32'h0);
    check("x0_rs2", rs2_data, 32'h0);

    // Write disable holds x7
    do_write(5'd7, 32'h0BADF00D, 1'b1);
    for (int i = 0; i < 3; i++) do_write(5'd7, 32'h12345678, 1'b0);
    check("wren0_x7", dut.register_array[7], 32'h0BADF00D);

    // Random writes checked one edge later
    for (int i = 0; i < 100; i++) begin
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      do_write(a, d, 1'b1);
      check("sweep_wr", dut.register_array[a], model[a]);
    end
    for (int i = 0; i < 100; i++) begin
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      rs1_addr = a;
      rs2_addr = b;
      #1;
      check("sweep_rs1", rs1_data, model[a]);
      check("sweep_rs2", rs2_data, model[b]);
    end

    // Same-cycle collision on x3
    do_write(5'd3, 32'h00000001, 1'b1);
`ifdef REGFILE_BYPASS_EN
    coll_exp = 32'hA5A5A5A5;
`else
    coll_exp = 32'h00000001;
`endif
    @(negedge clk);
    rd_addr  = 5'd3;
    rd_data  = 32'hA5A5A5A5;
    rd_wren  = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    #1;
    check("coll_pre_rs1", rs1_data, coll_exp);
    check("coll_pre_rs2", rs2_data, coll_exp);
    @(posedge clk);
    #1;
    rd_wren = 1'b0;
    model[3] = 32'hA5A5A5A5;
    check("coll_post_rs1", rs1_data, 32'hA5A5A5A5);
    check("coll_post_rs2", rs2_data, 32'hA5A5A5A5);

    // Async reset mid-cycle after writes; reset beats a pending write
    do_write(5'd9, 32'hCAFEF00D, 1'b1);
    check("pre_reset_x9", dut.register_array[9], 32'hCAFEF00D);
    @(negedge clk);
    #2;
    rd_addr  = 5'd9;
    rd_data  = 32'h55AA55AA;
    rd_wren  = 1'b1;
    rs1_addr = 5'd9;
    rst_n    = 1'b0;
    #1;
    check("rst_async_x9", dut.register_array[9], 32'h0);
    check("rst_bypass_rs1", rs1_data, 32'h0);
    @(posedge clk);
    #1;
    check("rst_prio_x9", dut.register_array[9], 32'h0);
    rd_wren = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      #1;
      check("rst_array", dut.register_array[i], 32'h0);
      check("rst_rs1", rs1_data, 32'h0);
      check("rst_rs2", rs2_data, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
